// File: rtl/riscv_multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The master drives the selects and strobes; the slave supplies decode fields and status.
interface riscv_multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       MemRead;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, MemRead, IRWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    output RegWrite, Illegal, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, MemRead, IRWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    input  RegWrite, Illegal, State
  );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32I control FSM: lw, sw, R/I ALU, beq, jal.
// Stalls on MemReady, halts sticky on unsupported encodings.
module riscv_multicycle_controller (
  input logic clk,
  input logic reset,
  riscv_multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_pcw, w_adr, w_mw, w_mr, w_irw, w_rw;
  logic [1:0] w_rs, w_sa, w_sb, w_imm;
  logic [2:0] w_alu;
  logic [2:0] w_dec_alu;
  logic       w_dec_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= (w_next == S_HALT);
    end
  end

  // ALU decode shared by EXECR and EXECI; sub only for R-type
  always_comb begin
    w_dec_alu = 3'b000;
    w_dec_ok  = 1'b1;
    unique case (bus.funct3)
      3'b000: w_dec_alu = (r_state == S_EXECR && bus.funct7b5)
                          ? 3'b001 : 3'b000;
      3'b010: w_dec_alu = 3'b101;
      3'b110: w_dec_alu = 3'b011;
      3'b111: w_dec_alu = 3'b010;
      default: w_dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_pcw  = 1'b0;
    w_adr  = 1'b0;
    w_mw   = 1'b0;
    w_mr   = 1'b0;
    w_irw  = 1'b0;
    w_rw   = 1'b0;
    w_rs   = 2'b00;
    w_sa   = 2'b00;
    w_sb   = 2'b00;
    w_imm  = 2'b00;
    w_alu  = 3'b000;
    unique case (r_state)
      S_FETCH: begin
        w_mr  = 1'b1;
        w_sb  = 2'b10;
        w_rs  = 2'b10;
        w_irw = bus.MemReady;
        w_pcw = bus.MemReady;
        if (bus.MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_sa  = 2'b01;
        w_sb  = 2'b01;
        w_imm = (bus.op == OP_J) ? 2'b11 : 2'b10;
        unique case (1'b1)
          (bus.op == OP_LW),
          (bus.op == OP_SW): w_next = S_MEMADR;
          (bus.op == OP_R):  w_next = S_EXECR;
          (bus.op == OP_I):  w_next = S_EXECI;
          (bus.op == OP_B):  w_next = S_BEQ;
          (bus.op == OP_J):  w_next = S_JAL;
          default:           w_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        w_sa   = 2'b10;
        w_sb   = 2'b01;
        w_imm  = (bus.op == OP_SW) ? 2'b01 : 2'b00;
        w_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr = 1'b1;
        w_mr  = 1'b1;
        if (bus.MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_rs   = 2'b01;
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr = 1'b1;
        w_mw  = 1'b1;
        if (bus.MemReady) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_sa   = 2'b10;
        w_alu  = w_dec_alu;
        w_next = w_dec_ok ? S_ALUWB : S_HALT;
      end
      S_EXECI: begin
        w_sa   = 2'b10;
        w_sb   = 2'b01;
        w_alu  = w_dec_alu;
        w_next = w_dec_ok ? S_ALUWB : S_HALT;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_BEQ: begin
        w_sa   = 2'b10;
        w_alu  = 3'b001;
        w_pcw  = bus.Zero && (bus.funct3 == 3'b000);
        w_next = (bus.funct3 == 3'b000) ? S_FETCH : S_HALT;
      end
      S_JAL: begin
        w_sa   = 2'b01;
        w_sb   = 2'b10;
        w_pcw  = 1'b1;
        w_next = S_ALUWB;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
    if (!reset) begin
      w_pcw = 1'b0;
      w_irw = 1'b0;
      w_mw  = 1'b0;
      w_mr  = 1'b0;
      w_rw  = 1'b0;
    end
  end

  assign bus.PCWrite    = w_pcw;
  assign bus.AdrSrc     = w_adr;
  assign bus.MemWrite   = w_mw;
  assign bus.MemRead    = w_mr;
  assign bus.IRWrite    = w_irw;
  assign bus.RegWrite   = w_rw;
  assign bus.ResultSrc  = w_rs;
  assign bus.ALUSrcA    = w_sa;
  assign bus.ALUSrcB    = w_sb;
  assign bus.ImmSrc     = w_imm;
  assign bus.ALUControl = w_alu;
  assign bus.Illegal    = r_illegal;
  assign bus.State      = r_state;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Randomized bench for the multicycle controller against a
// per-instruction-class reference of state walks and strobe counts.
module tb_riscv_multicycle_controller;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_multicycle_controller_if bus();
  riscv_multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] obs_st[$];
  logic [3:0] exp_st[$];
  int o_cyc, o_pc, o_ir, o_rw, o_mw, o_drop;
  logic [1:0] o_imm, o_rs;
  logic [2:0] o_alu;
  bit o_timeout;
  int e_pc, e_rw, e_mw;
  logic [1:0] e_imm;
  logic [2:0] e_alu;

  // Expected behaviour from the instruction class, stall counts and flags
  task automatic build_exp(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z,
                           input int sf, input int sm);
    bit f3ok;
    f3ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    exp_st.delete();
    repeat (sf + 1) exp_st.push_back(4'd0);
    exp_st.push_back(4'd1);
    e_pc = 1; e_rw = 0; e_mw = 0;
    e_imm = (o == OP_J) ? 2'd3 : 2'd2;
    case (f3)
      3'd0: e_alu = (o == OP_R && f7) ? 3'd1 : 3'd0;
      3'd2: e_alu = 3'd5;
      3'd6: e_alu = 3'd3;
      3'd7: e_alu = 3'd2;
      default: e_alu = 3'd0;
    endcase
    case (o)
      OP_LW: begin
        exp_st.push_back(4'd2);
        repeat (sm + 1) exp_st.push_back(4'd3);
        exp_st.push_back(4'd4);
        e_rw = 1;
      end
      OP_SW: begin
        exp_st.push_back(4'd2);
        repeat (sm + 1) exp_st.push_back(4'd5);
        e_mw = sm + 1;
      end
      OP_R, OP_I: begin
        exp_st.push_back((o == OP_R) ? 4'd6 : 4'd7);
        exp_st.push_back(f3ok ? 4'd8 : 4'd15);
        e_rw = f3ok ? 1 : 0;
      end
      OP_B: begin
        exp_st.push_back(4'd9);
        if (f3 != 3'd0) exp_st.push_back(4'd15);
        else if (z) e_pc = 2;
      end
      OP_J: begin
        exp_st.push_back(4'd10);
        exp_st.push_back(4'd8);
        e_pc = 2; e_rw = 1;
      end
      default: exp_st.push_back(4'd15);
    endcase
  endtask

  // Runs one instruction from FETCH, entered just after a rising edge
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z,
                           input int sf, input int sm);
    int fw, mw;
    bit left;
    logic [3:0] s;
    obs_st.delete();
    o_cyc = 0; o_pc = 0; o_ir = 0; o_rw = 0; o_mw = 0; o_drop = 0;
    o_imm = 2'd0; o_rs = 2'd3; o_alu = 3'd7;
    o_timeout = 1'b1; fw = 0; mw = 0; left = 1'b0;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
    for (int c = 0; c < 80; c++) begin
      s = bus.State;
      if (s == 4'd0 && left) begin
        o_timeout = 1'b0;
        break;
      end
      if (s == 4'd0) begin
        bus.MemReady = (fw >= sf); fw++;
      end else if (s == 4'd3 || s == 4'd5) begin
        bus.MemReady = (mw >= sm); mw++;
      end else begin
        bus.MemReady = 1'($urandom);
      end
      #1;
      obs_st.push_back(s);
      o_pc += int'(bus.PCWrite);
      o_ir += int'(bus.IRWrite);
      o_rw += int'(bus.RegWrite);
      o_mw += int'(bus.MemWrite);
      if ((s == 4'd0 || s == 4'd3) && !bus.MemRead) o_drop++;
      if (s == 4'd5 && !bus.MemWrite) o_drop++;
      if (s == 4'd1) o_imm = bus.ImmSrc;
      if (s == 4'd6 || s == 4'd7) o_alu = bus.ALUControl;
      if (s == 4'd8) o_rs = bus.ResultSrc;
      if (s == 4'd15) begin
        o_timeout = 1'b0;
        break;
      end
      o_cyc++;
      if (s != 4'd0) left = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.op = 7'($urandom); bus.funct3 = 3'($urandom);
    bus.funct7b5 = 1'($urandom); bus.Zero = 1'($urandom);
    bus.MemReady = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.State !== 4'd0 || bus.Illegal !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: State=%0d Illegal=%b, want 0/0",
               bus.State, bus.Illegal);
    end
    n_cmp++;
    if ({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.MemRead,
         bus.RegWrite} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b, want 00000",
               {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.MemRead,
                bus.RegWrite});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.MemRead !== 1'b1 || bus.AdrSrc !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fetch: MemRead=%b AdrSrc=%b, want 1/0",
               bus.MemRead, bus.AdrSrc);
    end
  endtask

  task automatic test_alu();
    logic [6:0] ops [3] = '{OP_R, OP_I, OP_R};
    logic       f7s [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      run_instr(ops[k], 3'd0, f7s[k], 1'b0, 0, 0);
      build_exp(ops[k], 3'd0, f7s[k], 1'b0, 0, 0);
      n_cmp++;
      if (obs_st != exp_st || o_timeout) begin
        n_err++;
        $display("FAIL alu_states[%0d]: got %p, want %p", k, obs_st, exp_st);
      end
      n_cmp++;
      if (o_alu !== e_alu || o_rw !== e_rw || o_rs !== 2'd0) begin
        n_err++;
        $display("FAIL alu_ctl[%0d]: alu=%0d rw=%0d rs=%0d, want %0d/%0d/0",
                 k, o_alu, o_rw, o_rs, e_alu, e_rw);
      end
    end
  endtask

  task automatic test_lw_stall();
    run_instr(OP_LW, 3'd2, 1'b0, 1'b0, 3, 2);
    build_exp(OP_LW, 3'd2, 1'b0, 1'b0, 3, 2);
    n_cmp++;
    if (o_cyc !== 10 || obs_st != exp_st) begin
      n_err++;
      $display("FAIL lw_stall_cycles: got %0d %p, want 10 %p",
               o_cyc, obs_st, exp_st);
    end
    n_cmp++;
    if (o_ir !== 1 || o_pc !== 1 || o_rw !== 1 || o_drop !== 0) begin
      n_err++;
      $display("FAIL lw_stall_strobes: ir=%0d pc=%0d rw=%0d drop=%0d, want 1/1/1/0",
               o_ir, o_pc, o_rw, o_drop);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      run_instr(OP_B, 3'd0, 1'b0, 1'(z), 0, 0);
      build_exp(OP_B, 3'd0, 1'b0, 1'(z), 0, 0);
      n_cmp++;
      if (o_cyc !== 3 || obs_st != exp_st || o_pc !== e_pc) begin
        n_err++;
        $display("FAIL beq_z%0d: cyc=%0d pc=%0d, want 3/%0d", z, o_cyc,
                 o_pc, e_pc);
      end
    end
  endtask

  task automatic test_jal();
    run_instr(OP_J, 3'($urandom), 1'b0, 1'($urandom), 0, 0);
    build_exp(OP_J, 3'd0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_st != exp_st || o_pc !== 2 || o_cyc !== 4) begin
      n_err++;
      $display("FAIL jal_flow: states=%p pc=%0d cyc=%0d, want %p 2 4",
               obs_st, o_pc, o_cyc, exp_st);
    end
    n_cmp++;
    if (o_imm !== 2'd3 || o_rw !== 1 || o_rs !== 2'd0) begin
      n_err++;
      $display("FAIL jal_ctl: imm=%0d rw=%0d rs=%0d, want 3/1/0",
               o_imm, o_rw, o_rs);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_J};
    logic [2:0] f3s [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
    logic [6:0] o;
    logic [2:0] f3;
    logic f7, z;
    int sf, sm;
    for (int k = 0; k < 40; k++) begin
      o  = ops[$urandom_range(0, 5)];
      f3 = (o == OP_R || o == OP_I) ? f3s[$urandom_range(0, 3)]
         : (o == OP_B) ? 3'd0 : 3'($urandom);
      f7 = 1'($urandom); z = 1'($urandom);
      sf = $urandom_range(0, 3); sm = $urandom_range(0, 3);
      run_instr(o, f3, f7, z, sf, sm);
      build_exp(o, f3, f7, z, sf, sm);
      n_cmp++;
      if (obs_st != exp_st || o_timeout || o_cyc !== exp_st.size()) begin
        n_err++;
        $display("FAIL rnd_states[%0d] op=%b: got %p, want %p",
                 k, o, obs_st, exp_st);
      end
      n_cmp++;
      if (o_pc !== e_pc || o_ir !== 1 || o_rw !== e_rw ||
          o_mw !== e_mw || o_drop !== 0 || o_imm !== e_imm) begin
        n_err++;
        $display("FAIL rnd_strobes[%0d] op=%b: pc=%0d rw=%0d mw=%0d drop=%0d imm=%0d, want %0d/%0d/%0d/0/%0d",
                 k, o, o_pc, o_rw, o_mw, o_drop, o_imm, e_pc, e_rw, e_mw,
                 e_imm);
      end
      if ((o == OP_R || o == OP_I) && o_alu !== e_alu) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_alu[%0d]: got %0d, want %0d", k, o_alu, e_alu);
      end else if (o == OP_R || o == OP_I) begin
        n_cmp++;
      end
    end
  endtask

  task automatic test_halt();
    logic [6:0] ops [2] = '{7'b1110011, OP_R};
    logic [2:0] f3s [2] = '{3'd0, 3'd1};
    int bad;
    for (int k = 0; k < 2; k++) begin
      run_instr(ops[k], f3s[k], 1'b0, 1'b0, 0, 0);
      build_exp(ops[k], f3s[k], 1'b0, 1'b0, 0, 0);
      n_cmp++;
      if (obs_st != exp_st || o_timeout || o_rw !== 0) begin
        n_err++;
        $display("FAIL halt_entry[%0d]: got %p rw=%0d, want %p 0",
                 k, obs_st, o_rw, exp_st);
      end
      bad = 0;
      repeat (20) begin
        @(posedge clk); #1;
        bus.MemReady = 1'($urandom); bus.Zero = 1'($urandom);
        #1;
        if (bus.State !== 4'd15 || bus.Illegal !== 1'b1 ||
            {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.MemRead,
             bus.RegWrite} !== 5'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
        n_err++;
        $display("FAIL halt_sticky[%0d]: %0d bad cycles, want 0", k, bad);
      end
      do_reset();
      n_cmp++;
      if (bus.Illegal !== 1'b0 || bus.State !== 4'd0) begin
        n_err++;
        $display("FAIL halt_clear[%0d]: Illegal=%b State=%0d, want 0/0",
                 k, bus.Illegal, bus.State);
      end
    end
  endtask

  task automatic test_sw_reset();
    bus.op = OP_SW; bus.funct3 = 3'd2; bus.MemReady = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.MemReady = 1'b0;
    #1;
    n_cmp++;
    if (bus.State !== 4'd5 || bus.MemWrite !== 1'b1) begin
      n_err++;
      $display("FAIL sw_memwrite: State=%0d MemWrite=%b, want 5/1",
               bus.State, bus.MemWrite);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.MemWrite !== 1'b0) begin
      n_err++;
      $display("FAIL sw_reset_drop: MemWrite=%b, want 0", bus.MemWrite);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    n_cmp++;
    if (bus.State !== 4'd0) begin
      n_err++;
      $display("FAIL sw_reset_fetch: State=%0d, want 0", bus.State);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.MemReady = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_alu();
    test_lw_stall();
    test_beq();
    test_jal();
    test_back_to_back();
    test_halt();
    test_sw_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_controller.md
# riscv_multicycle_controller

Control FSM that sequences a multicycle RV32I datapath with a shared instruction/data memory, a non-architectural instruction register and ALU-output registers. It decodes the latched instruction and drives every datapath select and write strobe one state per cycle. It stalls on a memory ready handshake and halts on unsupported instructions. It supports lw, sw, R-type ALU, I-type ALU, beq and jal.

## Interface
Parameters:
- none (encodings fixed below).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset. Reset is applied when reset==0 at a rising clk edge.
- op  in  7  opcode from the instruction register, Instr[6:0].
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write request.
- MemRead  out  1  memory read request.
- IRWrite  out  1  loads Instr and OldPC.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RegWrite  out  1  register file write enable.
- Illegal  out  1  sticky halt flag.
- State  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, HALT 15. Any other code returns to FETCH.
- FETCH
  - Drives AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10.
  - If MemReady=1: IRWrite=1, PCWrite=1, go to DECODE.
  - Otherwise stay in FETCH with IRWrite=0 and PCWrite=0.
- DECODE
  - Drives ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add. This computes the branch target into ALUOut.
  - Next state by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; any other op → HALT.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=00 for lw, 01 for sw. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00, MemRead=1. Stays until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held for every cycle until MemReady=1, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALU decode, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ
  - Drives ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = Zero.
  - Then FETCH.
  - funct3≠000 goes to HALT with no PCWrite.
- JAL
  - Drives ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. The PC is loaded from ALUOut (the target computed in DECODE with ImmSrc=11).
  - Then ALUWB, which writes rd=PC+4.
  - DECODE uses ImmSrc=11 when op=1101111.
- ALU decode for EXECR/EXECI:
  - funct3 000: sub if (EXECR and funct7b5), otherwise add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Any other funct3 → next state HALT with no RegWrite.
- HALT: all strobes are 0 and Illegal=1. HALT is exited only by reset.
- Outputs not listed for a state take these defaults: strobes 0, selects 00, ALUControl 000.

## Timing
- All outputs are combinational from State, plus Zero/MemReady where specified. State and Illegal are registered.
- Reset (reset==0 at an edge): State←FETCH and Illegal←0.
  - While reset==0, PCWrite, IRWrite, MemWrite, MemRead and RegWrite are forced to 0.
  - Reset mid-instruction abandons the instruction. Nothing is committed in the reset cycle.
- Latency with MemReady tied to 1:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Request signals (MemRead, MemWrite) stay stable and asserted until the accepting cycle.
- Exactly one PCWrite pulse per fetched instruction. A taken beq or a jal adds a second pulse.

## Test plan
- Reset: reset=0 for 2 cycles with random inputs → State=0, all write strobes 0, Illegal=0. After release, FETCH drives MemRead=1.
- add then addi (op 0110011/funct3 000/funct7b5 0, then 0010011), MemReady=1 → states 0,1,6,8 then 0,1,7,8. ALUControl=000 and RegWrite pulses in ALUWB. sub (funct7b5=1) gives 001.
- lw with MemReady low 3 cycles in FETCH and 2 in MEMREAD → 10 total cycles. IRWrite and PCWrite pulse once. MemRead is held until accepted.
- beq with Zero=1 → PCWrite in BEQ. With Zero=0 → no PCWrite. Both take 3 cycles.
- jal → PCWrite in FETCH and in JAL. ImmSrc=11 in DECODE. RegWrite with ResultSrc=00 in ALUWB.
- op 1110011 or funct3 001 R-type → HALT, Illegal=1 stays for 20 cycles. sw interrupted by reset in MEMWRITE → MemWrite drops, FETCH next.
